// File: rtl/egress_fifo_pkg.sv
// Constants shared by the 4-way routing mux and the per-port egress buffers.
package egress_fifo_pkg;

  localparam int unsigned WIDTH_PKT = 10;
  localparam int unsigned DEST_MSB  = 9;
  localparam int unsigned DEST_LSB  = 8;

  // Reset state code used by the switch controller.
  localparam logic [3:0] SW_RST_STATE = 4'b0001;

  // Destination field of a packet word.
  function automatic logic [DEST_MSB-DEST_LSB:0] dest_of(input logic [WIDTH_PKT-1:0] word);
    return word[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/egress_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one synchronous read port, no reset.
module egress_fifo_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write and read ports; a same-edge read of the written entry returns the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/egress_fifo.sv
// Per-port egress buffer: in-order storage, pop handshake, fill flags and sticky errors.
module egress_fifo
  import egress_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_PKT,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  input  logic [AW:0]      umbral_af,
  input  logic [AW:0]      umbral_ae,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] rd_data;

  egress_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Accept decisions, pointer/count next state and sticky error update.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A full buffer still takes a word when a pop frees a slot on the same edge.
    push_ok  = push && ((count_q != CountFull) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    valid_d  = pop_ok;
    ovf_d    = ovf_q || (push && !pop && (count_q == CountFull));
    udf_d    = udf_q || (pop && (count_q == '0));
  end

  // State registers with asynchronous reset; memory contents are left as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Outputs: data is forced to zero whenever the previous edge popped nothing.
  always_comb begin
    data_out      = valid_q ? rd_data : '0;
    valid_out     = valid_q;
    count         = count_q;
    full          = (count_q == CountFull);
    empty         = (count_q == '0);
    almost_full   = (count_q >= umbral_af);
    almost_empty  = (count_q <= umbral_ae);
    overflow_err  = ovf_q;
    underflow_err = udf_q;
  end

endmodule

// File: tb/tb_egress_fifo.sv
// Self-checking bench for egress_fifo: constant vector table, corner sequences, random vs queue model.
module tb_egress_fifo;

  localparam int W = 10;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         push, pop;
  logic [A:0]   umbral_af, umbral_ae;
  logic [W-1:0] data_out;
  logic         valid_out, full, empty, almost_full, almost_empty;
  logic [A:0]   count;
  logic         overflow_err, underflow_err;

  egress_fifo #(
    .WIDTH (W),
    .DEPTH (D),
    .AW    (A)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .push          (push),
    .pop           (pop),
    .umbral_af     (umbral_af),
    .umbral_ae     (umbral_ae),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: plain queue of stored words plus sticky error bits.
  logic [W-1:0] mq[$];
  logic         m_ovf, m_udf;
  logic         e_valid;
  logic [W-1:0] e_dout;

  typedef struct {
    logic       p;
    logic       r;
    logic [9:0] d;
    int         cnt;
    logic       v;
    logic [9:0] q;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       udf;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, " count"}, int'(count), sz);
    chk({tag, " full"}, int'(full), int'(sz == D));
    chk({tag, " empty"}, int'(empty), int'(sz == 0));
    chk({tag, " almost_full"}, int'(almost_full), int'(sz >= int'(umbral_af)));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(sz <= int'(umbral_ae)));
    chk({tag, " valid_out"}, int'(valid_out), int'(e_valid));
    chk({tag, " data_out"}, int'(data_out), int'(e_dout));
    chk({tag, " overflow_err"}, int'(overflow_err), int'(m_ovf));
    chk({tag, " underflow_err"}, int'(underflow_err), int'(m_udf));
  endtask

  // One clock cycle: drive at negedge, update model, check 1 time unit after posedge.
  task automatic step(input logic p, input logic r, input logic [W-1:0] d, input string tag);
    int sz;
    @(negedge clk);
    push    = p;
    pop     = r;
    data_in = d;
    sz      = mq.size();
    e_valid = r && (sz > 0);
    e_dout  = e_valid ? mq[0] : '0;
    if (p && !r && sz == D) m_ovf = 1'b1;
    if (r && sz == 0) m_udf = 1'b1;
    if (e_valid) void'(mq.pop_front());
    if (p && (sz < D || r)) mq.push_back(d);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must settle before the next edge.
  task automatic apply_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    chk({tag, " rst count"}, int'(count), 0);
    chk({tag, " rst empty"}, int'(empty), 1);
    chk({tag, " rst full"}, int'(full), 0);
    chk({tag, " rst almost_empty"}, int'(almost_empty), 1);
    chk({tag, " rst almost_full"}, int'(almost_full), int'(umbral_af == 0));
    chk({tag, " rst data_out"}, int'(data_out), 0);
    chk({tag, " rst valid_out"}, int'(valid_out), 0);
    chk({tag, " rst overflow_err"}, int'(overflow_err), 0);
    chk({tag, " rst underflow_err"}, int'(underflow_err), 0);
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    e_valid = 1'b0;
    e_dout  = '0;
    #1 reset = 1'b0;
  endtask

  function automatic logic [W-1:0] fill_word(input int i);
    logic [1:0] dst;
    logic [7:0] lo;
    dst = 2'(i % 4);
    lo  = 8'(i + 1);
    return {dst, lo};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    data_in   = '0;
    umbral_af = 4'd6;
    umbral_ae = 4'd1;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;

    //            p  r  d       cnt v  q       fu em af ae udf
    tbl[0] = '{1, 0, 10'h301, 1, 0, 10'h000, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 0, 10'h102, 2, 0, 10'h000, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 10'h203, 3, 0, 10'h000, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 10'h000, 2, 1, 10'h301, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 10'h000, 1, 1, 10'h102, 0, 0, 0, 1, 0};
    tbl[5] = '{0, 1, 10'h000, 0, 1, 10'h203, 0, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 0, 1, 0};
    tbl[7] = '{0, 1, 10'h000, 0, 0, 10'h000, 0, 1, 0, 1, 1};
    tbl[8] = '{1, 1, 10'h155, 1, 0, 10'h000, 0, 0, 0, 1, 1};
    tbl[9] = '{0, 1, 10'h000, 0, 1, 10'h155, 0, 1, 0, 1, 1};

    apply_reset("init");

    // Vector table: ordered read-out, pop on empty, push+pop on empty.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].p, tbl[i].r, tbl[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d valid", i), int'(valid_out), int'(tbl[i].v));
      chk($sformatf("tbl%0d dout", i), int'(data_out), int'(tbl[i].q));
      chk($sformatf("tbl%0d full", i), int'(full), int'(tbl[i].full));
      chk($sformatf("tbl%0d empty", i), int'(empty), int'(tbl[i].empty));
      chk($sformatf("tbl%0d af", i), int'(almost_full), int'(tbl[i].af));
      chk($sformatf("tbl%0d ae", i), int'(almost_empty), int'(tbl[i].ae));
      chk($sformatf("tbl%0d udf", i), int'(underflow_err), int'(tbl[i].udf));
    end

    // Fill to full, overflow drop, push+pop while full, drain in order.
    apply_reset("fill");
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, fill_word(i), "fill");
      chk("fill almost_full", int'(almost_full), int'(i >= 5));
    end
    chk("fill full", int'(full), 1);
    step(1'b1, 1'b0, 10'h3ff, "ovf");
    chk("ovf flag", int'(overflow_err), 1);
    chk("ovf count", int'(count), D);
    step(1'b1, 1'b1, 10'h3aa, "full_pp");
    chk("full_pp count", int'(count), D);
    chk("full_pp dout", int'(data_out), int'(fill_word(0)));
    for (int i = 1; i < D; i++) begin
      step(1'b0, 1'b1, '0, "drain");
      chk("drain order", int'(data_out), int'(fill_word(i)));
    end
    step(1'b0, 1'b1, '0, "drain_last");
    chk("drain_last dout", int'(data_out), 'h3aa);
    chk("drain_last empty", int'(empty), 1);

    // Back-to-back streaming: 20 words, pointers wrap twice.
    apply_reset("stream");
    step(1'b1, 1'b0, 10'h100, "stream0");
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 1'b1, W'(10'h100 + i), "stream");
      chk("stream count<=1", int'(count <= 1), 1);
      chk("stream dout", int'(data_out), 'h100 + i - 1);
    end
    step(1'b0, 1'b1, '0, "stream_end");
    chk("stream_end dout", int'(data_out), 'h100 + 19);

    // Asynchronous reset with five words stored, then normal operation.
    apply_reset("pre_async");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, fill_word(i + 3), "async_fill");
    chk("async pre count", int'(count), 5);
    apply_reset("async");
    step(1'b1, 1'b0, 10'h2a5, "post_push");
    step(1'b0, 1'b1, '0, "post_pop");
    chk("post_pop dout", int'(data_out), 'h2a5);
    chk("post_pop empty", int'(empty), 1);

    // Randomized traffic and thresholds against the queue model.
    apply_reset("rand");
    for (int i = 0; i < 400; i++) begin
      logic         p, r;
      logic [W-1:0] d;
      if (i % 50 == 0) begin
        umbral_af = 4'($urandom_range(0, 15));
        umbral_ae = 4'($urandom_range(0, 15));
      end
      p = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      d = W'($urandom_range(1, 1023));
      step(p, r, d, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/egress_fifo.md
# egress_fifo

Per-port egress buffer on the PCIe transaction-layer switch path, directly downstream of the 4-way routing mux. One instance per output port (Out0–Out3). Each instance captures the 10-bit words the mux steers to its port, stores them in order, and drains them to the next stage under a pop handshake. It reports fill state (full/empty plus programmable almost-full/almost-empty) for upstream flow control.

## Interface
Parameters:
- WIDTH, 10, word width; bits [9:8] carry the destination field, and all-zero means "no word".
- DEPTH, 8, number of entries; must be a power of two, ≥ 4.
- AW, 3, address width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word from the mux output for this port.
- push  input  1  write request; at integration it is tied to (data_in != 0).
- pop  input  1  read request from the downstream stage.
- umbral_af  input  AW+1  almost-full threshold.
- umbral_ae  input  AW+1  almost-empty threshold.
- data_out  output  WIDTH  word read out; registered.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- full, empty  output  1  fill state.
- almost_full, almost_empty  output  1  threshold flags.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow_err, underflow_err  output  1  sticky error flags.

## Operation
- Storage is a circular buffer with wr_ptr and rd_ptr, each AW bits wide, plus a separate count register of AW+1 bits. Both pointers wrap from DEPTH-1 to 0.
- Push accepted when push=1 and either count<DEPTH, or count=DEPTH and pop=1 in the same cycle. An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Pop accepted when pop=1 and count>0. An accepted pop loads data_out from mem[rd_ptr], sets valid_out=1 and increments rd_ptr.
- A cycle with no accepted pop drives data_out=0 and valid_out=0. Downstream therefore always sees 0 when there is no word.
- count: +1 on push only, −1 on pop only, unchanged when both are accepted.
- Full with push and pop in the same cycle: both are accepted and count stays at DEPTH.
- Empty with push and pop in the same cycle: the push is stored, the pop is rejected (no fall-through), and underflow_err is set.
- Push while full without pop: the word is dropped, nothing changes, and overflow_err is set.
- Pop while empty: underflow_err is set and data_out/valid_out are 0.
- overflow_err and underflow_err stay set until reset.
- Flags are combinational from the registered count:
  - full = (count==DEPTH); empty = (count==0).
  - almost_full = (count ≥ umbral_af); almost_empty = (count ≤ umbral_ae).
  - Thresholds are compared unsigned. A threshold above DEPTH makes that flag behave as the comparison dictates; no clamping.
- Reset (asynchronous, any time, including mid-burst):
  - Pointers and count go to 0; data_out=0; valid_out=0; both error flags=0.
  - Resulting flags: empty=1, full=0, almost_empty=1 if umbral_ae≥0 (always), almost_full=(umbral_af==0).
  - Memory contents are not cleared; they are unreachable until rewritten.

## Timing
- Write-to-readable latency is 1 cycle: a word pushed at edge N can be popped at edge N+1, and it appears on data_out after edge N+1.
- Read latency is 1 cycle: a pop sampled at edge N gives data_out/valid_out valid from edge N until edge N+1.
- count and the flags update on the same edge as the accepted push/pop.
- Throughput is one push and one pop per cycle, sustained.

## Structure
- Shared package holds WIDTH_PKT=10, DEST_MSB=9, DEST_LSB=8 and the reset state code 4'b0001 used by the switch controller. The mux and this block share these constants.
- One sub-module, egress_fifo_mem: a DEPTH×WIDTH register file with one synchronous write port and one synchronous read port, no reset.
- The pointers, count, flags and error logic stay in egress_fifo.

## Test plan
- Reset with umbral_af=6, umbral_ae=1 → count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, valid_out=0.
- Push 10'h301, 10'h102, 10'h203, then pop 3 times → data_out 10'h301, 10'h102, 10'h203 with valid_out=1, then empty=1.
- Push 8 words → full=1, almost_full=1 from count=6. Ninth push without pop → word dropped, overflow_err=1, count=8. Then push and pop in the same cycle → count stays 8 and the order is preserved.
- Pop on empty, and separately push+pop on empty → underflow_err=1, data_out=0. In the second case the pushed word reads out on the next pop.
- Push and pop 20 words back-to-back → pointers wrap twice, the output sequence matches the input, and count never exceeds 1.
- Assert reset asynchronously mid-way with count=5 → all outputs return to their reset values before the next clk edge, and a following push/pop cycle works normally.
